uart_boot_loader: RTL
=====================

// Module: uart_boot_loader
// PURPOSE
//  UART bootloader and upstream feeder of the shared instruction/data memory's write port.
//  - Receives a framed program image over a serial line, packs the bytes into 32-bit words and writes them to memory.
//  - Holds rv32i_core in reset until the load completes; the SoC then releases the core to fetch from PC_RESET.
// PARAMETERS
//  CLK_FREQ_MHZ  100      system clock frequency, MHz
//  BAUD_RATE     115200   serial rate; CLKS_PER_BIT = CLK_FREQ_MHZ*1_000_000/BAUD_RATE (integer, >=4)
//  MEMORY_DEPTH  1024     memory size in bytes; capacity MAX_WORDS = MEMORY_DEPTH/4
// PORTS
//  i_clk          in   1                       system clock, all logic on rising edge
//  i_rst_n        in   1                       asynchronous active-low reset
//  i_uart_rx      in   1                       serial input, idle high, 8N1, LSB first
//  o_mem_addr     out  $clog2(MEMORY_DEPTH)    byte address of word being written (multiple of 4)
//  o_mem_data     out  32                      word to write
//  o_mem_wr_mask  out  4                       byte-lane write mask
//  o_mem_wr_en    out  1                       single-cycle write strobe
//  o_core_rst_n   out  1                       active-low reset to the core; high only in DONE
//  o_busy         out  1                       high from header accepted until DONE/ERROR
//  o_done         out  1                       sticky: image loaded
//  o_error        out  1                       sticky: framing/length/checksum error
// BEHAVIOUR
//  Reset values: o_mem_addr=0, o_mem_data=0, o_mem_wr_mask=0, o_mem_wr_en=0, o_core_rst_n=0, o_busy=0, o_done=0, o_error=0.
//  RX front end:
//   - i_uart_rx passes through a 2-flop synchronizer.
//   - A falling edge while RX is idle starts a frame. The start bit is re-checked at half a bit time; if high, the frame is dropped silently.
//   - Data bits are sampled at bit centres, every CLKS_PER_BIT clocks. The stop bit is sampled at its centre.
//   - Stop=1: a one-cycle byte_valid pulse is produced. Stop=0: framing error, FSM goes to ERROR.
//  Frame format: 0xA5 header, word count N (2 bytes, little-endian), N words of 4 bytes each (little-endian).
//  FSM states: WAIT_HDR -> CNT_LO -> CNT_HI -> PAYLOAD -> (CHECK) -> DONE | ERROR.
//   - WAIT_HDR: bytes other than 0xA5 are ignored. 0xA5 sets o_busy=1 and moves to CNT_LO.
//   - CNT_HI: N > MAX_WORDS -> ERROR, with no writes. N == 0 -> DONE, or CHECK when checksum is compiled in.
//   - PAYLOAD: a byte counter (0..3) shifts bytes into a word register, byte k into bits [8k+7:8k].
//     - The cycle after the 4th byte_valid: o_mem_wr_en=1 for exactly 1 cycle, o_mem_wr_mask=4'b1111, o_mem_addr=4*word_index.
//     - word_index then increments. Once word_index reaches N, go to DONE.
//   - Outside that cycle, o_mem_wr_en=0 and o_mem_wr_mask=0.
//   - DONE: o_done=1, o_busy=0, o_core_rst_n=1. RX is ignored. Sticky until i_rst_n.
//   - ERROR: o_error=1, o_busy=0, o_core_rst_n=0. RX is ignored. Sticky until i_rst_n. Writes already issued are not undone.
//  Boundary conditions:
//   - Address width: word_index*4 fits $clog2(MEMORY_DEPTH) bits because N <= MAX_WORDS. N == MAX_WORDS is legal; the last word goes to MEMORY_DEPTH-4.
//   - A byte_valid arriving in the same cycle as a write strobe is captured normally; the strobe and the shift register are independent.
//   - Reset asserted mid-load: all state and outputs return to reset values immediately. The next load starts again from WAIT_HDR at address 0.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined:
//   - After the last payload word, the FSM enters CHECK and waits for one extra byte.
//   - Byte == XOR of all payload bytes (initial value 0x00; header and count bytes excluded) -> DONE. Otherwise -> ERROR.
//  BOOT_CHECKSUM_EN undefined: the CHECK state and XOR register are absent; the FSM goes PAYLOAD -> DONE directly.
// TESTING (CLK_FREQ_MHZ=100, BAUD_RATE=1_000_000 -> 100 clks/bit)
//  1. Send A5 02 00 78 56 34 12 EF BE AD DE -> writes 0x12345678@0 and 0xDEADBEEF@4, each mask 4'hF for 1 cycle; then o_done=1, o_core_rst_n=1.
//  2. Send 00 FF 5A before the stream of test 1 -> leading bytes ignored; identical writes and result.
//  3. Send A5 01 01 (N=257 > 256) -> o_error=1, zero write strobes, o_core_rst_n=0.
//  4. Test 1 stream with the stop bit of the 5th byte driven 0 -> o_error=1, only preceding writes (none) issued, o_busy=0.
//  5. Pulse i_rst_n low after the first write of test 1 -> outputs at reset values; resend full test 1 stream -> first write again @0.
//  6. BOOT_CHECKSUM_EN: test 1 stream + 2A -> o_done=1; test 1 stream + 2B -> o_error=1, both words still written.

Source files
------------

// File: rtl/uart_boot_loader_if.sv
// Memory write-port bundle driven by the UART boot loader.
// master drives the word write, slave is the memory side.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic [3:0]        wr_mask;
  logic              wr_en;

  modport master (output addr, data, wr_mask, wr_en);
  modport slave  (input  addr, data, wr_mask, wr_en);
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: 8N1 receiver, framed image unpacker, memory writer.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte check.
module uart_boot_loader #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 115200,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_uart_rx,
  uart_boot_loader_if.master  mem,
  output logic                o_core_rst_n,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  localparam int CPB       = CLK_FREQ_MHZ * 1_000_000 / BAUD_RATE;
  localparam int HALF      = CPB / 2;
  localparam int CW        = $clog2(CPB + 1);
  localparam int AW        = $clog2(MEMORY_DEPTH);
  localparam int MAX_WORDS = MEMORY_DEPTH / 4;

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  rx_st_t          rx_st, rx_nxt;
  logic [1:0]      sync;
  logic            rx_s, rx_q;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_byte;
  logic            half_tick, bit_tick;
  logic            byte_valid, frame_err;

  assign rx_s      = sync[1];
  assign half_tick = (cnt == CW'(HALF - 1));
  assign bit_tick  = (cnt == CW'(CPB - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= 2'b11;
      rx_q <= 1'b1;
    end else begin
      sync <= {sync[0], i_uart_rx};
      rx_q <= rx_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rx_st <= R_IDLE;
    else          rx_st <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_st;
    unique case (rx_st)
      R_IDLE:  if (rx_q && !rx_s) rx_nxt = R_START;
      R_START: if (half_tick) rx_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (bit_tick && bit_idx == 3'd7) rx_nxt = R_STOP;
      R_STOP:  if (bit_tick) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (rx_st == R_STOP) && bit_tick && rx_s;
    frame_err  = (rx_st == R_STOP) && bit_tick && !rx_s;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      if (rx_st == R_IDLE || rx_st != rx_nxt || bit_tick)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (rx_st == R_START)
        bit_idx <= '0;
      else if (rx_st == R_DATA && bit_tick) begin
        bit_idx <= bit_idx + 3'd1;
        rx_byte <= {rx_s, rx_byte[7:1]};
      end
    end
  end

  // ---------------- Loader FSM ----------------
  typedef enum logic [2:0] {
    S_HDR, S_CLO, S_CHI, S_PAY,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } st_t;

`ifdef BOOT_CHECKSUM_EN
  localparam st_t S_FIN = S_CHK;
`else
  localparam st_t S_FIN = S_DONE;
`endif

  st_t           st, nxt;
  logic [7:0]    cnt_lo;
  logic [15:0]   n_words;
  logic [15:0]   cnt_in;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_reg;
  logic [AW-2:0] word_idx;
  logic          last_word;
  logic          word_done;
  logic          wr_en_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign cnt_in    = {rx_byte, cnt_lo};
  assign last_word = (16'(word_idx) + 16'd1) == n_words;
  assign word_done = (st == S_PAY) && byte_valid && (byte_cnt == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) st <= S_HDR;
    else          st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_HDR:
        if (byte_valid && rx_byte == 8'hA5) nxt = S_CLO;
      S_CLO:
        if (byte_valid) nxt = S_CHI;
      S_CHI:
        if (byte_valid) begin
          if (cnt_in > 16'(MAX_WORDS)) nxt = S_ERR;
          else if (cnt_in == 16'd0)    nxt = S_FIN;
          else                         nxt = S_PAY;
        end
      S_PAY:
        if (word_done && last_word) nxt = S_FIN;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:
        if (byte_valid) nxt = (rx_byte == csum) ? S_DONE : S_ERR;
`endif
      S_DONE: nxt = S_DONE;
      S_ERR:  nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
    // Stop-bit failure aborts any load still in progress
    if (frame_err && st != S_DONE && st != S_ERR)
      nxt = S_ERR;
  end

  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_core_rst_n = 1'b0;
    unique case (st)
      S_CLO, S_CHI, S_PAY: o_busy = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:               o_busy = 1'b1;
`endif
      S_DONE: begin
        o_done       = 1'b1;
        o_core_rst_n = 1'b1;
      end
      S_ERR:               o_error = 1'b1;
      default: ;
    endcase
    mem.wr_en   = wr_en_q;
    mem.wr_mask = {4{wr_en_q}};
    mem.addr    = addr_q;
    mem.data    = data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_lo   <= '0;
      n_words  <= '0;
      byte_cnt <= '0;
      word_reg <= '0;
      word_idx <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_en_q <= word_done;
      if (st == S_CLO && byte_valid) cnt_lo  <= rx_byte;
      if (st == S_CHI && byte_valid) n_words <= cnt_in;
      if (st == S_PAY && byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_reg <= {rx_byte, word_reg[23:8]};
      end
      if (word_done) begin
        data_q   <= {rx_byte, word_reg};
        addr_q   <= {word_idx[AW-3:0], 2'b00};
        word_idx <= word_idx + 1'b1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    csum <= '0;
    else if (st == S_PAY && byte_valid) csum <= csum ^ rx_byte;
  end
`endif

endmodule
